// File: rtl/ota_pkg.sv
// Shared constants, handshake state type and result-scaling helper for the OTA
// comparator back-end blocks.
package ota_pkg;

  localparam int unsigned WIN_LOG2_DEF = 8;
  localparam int unsigned FILT_LEN_DEF = 3;
  localparam int unsigned RES_W_DEF    = 8;
  localparam int unsigned EDGE_W_DEF   = 4;
  localparam int unsigned RUN_W        = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hs_state_e;

  // Scale a high-cycle count down by 'shift' bits, clamped to res_w bits.
  function automatic logic [31:0] scale_sat(input logic [31:0] cnt,
                                            input int unsigned shift,
                                            input int unsigned res_w);
    logic [31:0] scaled;
    logic [31:0] max_val;
    scaled  = cnt >> shift;
    max_val = (32'd1 << res_w) - 32'd1;
    return (scaled > max_val) ? max_val : scaled;
  endfunction

endpackage

// File: rtl/ota_sync_filt.sv
// Two-flop synchroniser followed by a persistence filter: the output level only
// changes after FILT_LEN consecutive differing synchronised samples.
module ota_sync_filt
  import ota_pkg::*;
#(
  parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic filt
);

  logic             s1;
  logic             s2;
  logic [RUN_W-1:0] run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Run counter clears on agreement; toggles the level when the run completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= '0;
      filt <= 1'b0;
    end else if (s2 == filt) begin
      run <= '0;
    end else if (run == RUN_W'(FILT_LEN - 1)) begin
      run  <= '0;
      filt <= ~filt;
    end else begin
      run <= run + RUN_W'(1);
    end
  end

endmodule

// File: rtl/ota_duty_meter.sv
// Windowed duty-cycle and rising-edge meter on the filtered comparator output,
// with a valid/ack result handshake and sticky overrun flag.
module ota_duty_meter
  import ota_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF,
  parameter int unsigned FILT_LEN = FILT_LEN_DEF,
  parameter int unsigned RES_W    = RES_W_DEF,
  parameter int unsigned EDGE_W   = EDGE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cmp_in,
  input  logic              ack,
  output logic              cmp_filt,
  output logic              result_valid,
  output logic [RES_W-1:0]  result,
  output logic [EDGE_W-1:0] edges,
  output logic              overrun
);

  localparam int unsigned HC_W = WIN_LOG2 + 1;

  logic [WIN_LOG2-1:0] wcnt;
  logic [HC_W-1:0]     hcnt;
  logic [EDGE_W-1:0]   ecnt;
  logic                filt_prev;

  hs_state_e state;
  hs_state_e state_nxt;
  logic      overrun_nxt;
  logic      load_c;

  logic                rise_c;
  logic                win_end_c;
  logic [HC_W-1:0]     hsum_c;
  logic [EDGE_W-1:0]   esum_c;
  logic [RES_W-1:0]    res_c;

  ota_sync_filt #(
    .FILT_LEN(FILT_LEN)
  ) u_sync_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (cmp_in),
    .filt (cmp_filt)
  );

  // Accumulator values including the current cycle's sample.
  always_comb begin
    rise_c    = cmp_filt & ~filt_prev;
    win_end_c = ena && (wcnt == '1);
    hsum_c    = hcnt + HC_W'(cmp_filt);
    esum_c    = (rise_c && (ecnt != '1)) ? ecnt + EDGE_W'(1) : ecnt;
    res_c     = RES_W'(scale_sat(32'(hsum_c), WIN_LOG2 - RES_W, RES_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_prev <= 1'b0;
    end else begin
      filt_prev <= cmp_filt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      hcnt <= '0;
      ecnt <= '0;
    end else if (!ena || win_end_c) begin
      wcnt <= '0;
      hcnt <= '0;
      ecnt <= '0;
    end else begin
      wcnt <= wcnt + WIN_LOG2'(1);
      hcnt <= hsum_c;
      ecnt <= esum_c;
    end
  end

  // A pending result is only replaced when acknowledged in the same cycle.
  always_comb begin
    state_nxt   = state;
    overrun_nxt = overrun;
    load_c      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (win_end_c) begin
          load_c    = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (win_end_c) begin
          if (ack) begin
            load_c      = 1'b1;
            overrun_nxt = 1'b0;
          end else begin
            overrun_nxt = 1'b1;
          end
        end else if (ack) begin
          state_nxt   = ST_EMPTY;
          overrun_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      overrun <= 1'b0;
      result  <= '0;
      edges   <= '0;
    end else begin
      state   <= state_nxt;
      overrun <= overrun_nxt;
      if (load_c) begin
        result <= res_c;
        edges  <= esum_c;
      end
    end
  end

  assign result_valid = (state == ST_FULL);

endmodule

// File: doc/ota_duty_meter.md
Name: ota_duty_meter

Overview:
- Digital back-end stage downstream of the Digi-OTA comparator output.
- Samples the comparator's digital output (routed back in as a logic signal) and synchronises it.
- Removes glitches with a programmable persistence filter.
- Over fixed windows, measures duty cycle (high-cycle count) and rising-edge count, and presents each window's result with a valid/ack handshake to the pad-output logic.

Parameters:
- WIN_LOG2, 8: window length is 2^WIN_LOG2 clk cycles; must be >= RES_W.
- FILT_LEN, 3: consecutive identical synchronised samples needed to change the filtered level; 1..15.
- RES_W, 8: duty result width.
- EDGE_W, 4: rising-edge counter width; the counter saturates.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  measurement enable.
- cmp_in  in  1  comparator output; asynchronous to clk.
- ack  in  1  consumer acknowledge for result.
- cmp_filt  out  1  synchronised and filtered comparator level.
- result_valid  out  1  result/edges hold an unacknowledged window.
- result  out  RES_W  duty of the last window, as high-cycles scaled to RES_W bits.
- edges  out  EDGE_W  rising edges of cmp_filt in the last window, saturating.
- overrun  out  1  sticky: a window completed while a result was pending.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, named rst_n, as the codebase does.
- Reset (async assert, sync release): all flops 0. cmp_filt=0, result_valid=0, result=0, edges=0, overrun=0, window counter=0.
- Synchroniser: 2 flops (s1, s2) on cmp_in, always running regardless of ena.
- Filter:
  - 4-bit run counter compares s2 against cmp_filt.
  - If equal, the counter clears.
  - If different, the counter increments; when it reaches FILT_LEN, cmp_filt toggles and the counter clears.
  - Latency: a cmp_in change before edge k appears on cmp_filt after edge k+1+FILT_LEN (5 edges at the default).
  - Pulses shorter than FILT_LEN cycles, as seen at s2, never reach cmp_filt.
- Accumulation:
  - Applies only while ena=1.
  - Window counter wcnt (WIN_LOG2 bits) counts 0..2^WIN_LOG2-1, then wraps.
  - hcnt (WIN_LOG2+1 bits) increments on every cycle with cmp_filt=1.
  - ecnt increments on a 0->1 transition of cmp_filt, saturating at 2^EDGE_W-1.
- Window end: the cycle with wcnt = all-ones, with ena=1.
  - That cycle's own sample is included.
  - Result value = (hcnt_final >> (WIN_LOG2-RES_W)), saturated to 2^RES_W-1. hcnt_final = 2^WIN_LOG2 means all-high.
  - Accumulators restart from 0 on the next edge; the new window's first sample is included.
- ena=0: wcnt, hcnt and ecnt clear synchronously and hold at 0. Output registers and the handshake are unaffected.
- Handshake, evaluated at each edge:
  - Window end, no pending result (valid=0): load result/edges, valid <= 1.
  - Window end with valid=1 and ack=1 in the same cycle: load the new result, valid stays 1, no overrun.
  - Window end with valid=1 and ack=0: result/edges keep the OLD values, overrun <= 1, the new data is dropped.
  - ack=1 with valid=1, no window end: valid <= 0 next edge. overrun clears on the same ack.
  - ack while valid=0: ignored.
- result/edges are stable whenever valid=1. Only a window end can change them.
- Reset mid-window: everything returns to the reset state. The first window after release is a full 2^WIN_LOG2 cycles.

Decomposition:
- Shared package (ota_pkg): default WIN_LOG2/FILT_LEN/RES_W/EDGE_W constants, and a function for the saturating scale of hcnt to RES_W.
- One sub-module, ota_sync_filt: 2-flop synchroniser plus persistence filter; outputs cmp_filt. It is reusable for the Vip/Vin digital monitors.
- Window counters and handshake stay in the top.

Test Plan:
- cmp_in held 1, ena=1, ack pulsed after each valid -> from the second window on, result=255, edges=0, overrun=0. First window edges=1 because of the initial rise.
- cmp_in held 0 -> result=0, edges=0 every window. cmp_filt stays 0.
- cmp_in square wave, 8 high / 8 low, steady state -> result=128; edges saturates at 15 (16 rises).
- cmp_in square wave, period 64 (32/32) -> result=128, edges=4.
- cmp_in 2-cycle high glitches every 20 cycles, FILT_LEN=3 -> cmp_filt stays 0, result=0, edges=0.
- Handshake:
  - No ack across two window ends -> after the second, overrun=1 and result still equals window 1's value.
  - ack coincident with a window end -> valid stays 1, new value loaded, overrun=0.
  - rst_n pulsed mid-window -> all outputs 0 immediately; next valid exactly 256 cycles after release.
